// File: rtl/cfi_pkg.sv
// Shared CFI types: log entries, fault report, event flag encodings and fault causes.
// VLEN/XLEN mirror the core's virtual-address and register widths.
package cfi_pkg;

  localparam int unsigned VLEN = 39;
  localparam int unsigned XLEN = 64;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;

  typedef struct packed {
    logic [3:0]      flags;
    logic [VLEN-1:0] pc;
    logic [VLEN-1:0] target;
    logic            is_compressed;
  } cfi_log_t;

  localparam logic [3:0] CFI_FLAG_BRANCH = 4'b1000;
  localparam logic [3:0] CFI_FLAG_JUMP   = 4'b0100;
  localparam logic [3:0] CFI_FLAG_CALL   = 4'b0110;
  localparam logic [3:0] CFI_FLAG_RETURN = 4'b0101;

  localparam logic [XLEN-1:0] CFI_CAUSE_MISMATCH  = XLEN'(32'h20);
  localparam logic [XLEN-1:0] CFI_CAUSE_OVERFLOW  = XLEN'(32'h21);
  localparam logic [XLEN-1:0] CFI_CAUSE_UNDERFLOW = XLEN'(32'h22);

  typedef enum logic [1:0] {
    CFI_IDLE  = 2'd0,
    CFI_BUSY  = 2'd1,
    CFI_FAULT = 2'd2
  } cfi_state_e;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/cfi_shadow_stack.sv
// Circular LIFO of return addresses. In WRAP mode a push on a full stack
// overwrites the oldest entry, which is exactly the slot the write pointer sits on.
module cfi_shadow_stack
  import cfi_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter bit          WRAP  = 1'b0,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = PW + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic            clear_i,
  input  logic [VLEN-1:0] data_i,
  output logic [VLEN-1:0] top_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CW-1:0]   count_o
);

  logic [VLEN-1:0] mem_q [DEPTH];
  logic [PW-1:0]   wp_q, wp_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   top_idx;
  logic            wr_en;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign top_idx = wp_q - PW'(1);
  assign top_o   = mem_q[top_idx];

  always_comb begin
    wp_d  = wp_q;
    cnt_d = cnt_q;
    wr_en = 1'b0;
    if (clear_i) begin
      wp_d  = '0;
      cnt_d = '0;
    end else if (push_i && (!full_o || WRAP)) begin
      wr_en = 1'b1;
      wp_d  = wp_q + PW'(1);
      if (!full_o) cnt_d = cnt_q + CW'(1);
    end else if (pop_i && !empty_o) begin
      wp_d  = wp_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wp_q] <= data_i;
  end

endmodule

// File: rtl/cfi_backend_shadow_stack.sv
// CFI log backend: pops one event per accepted log entry, charges a per-type
// stall, and checks returns against a hardware shadow stack.
module cfi_backend_shadow_stack
  import cfi_pkg::*;
#(
  parameter int unsigned NR_STALL_BRANCH  = 1,
  parameter int unsigned NR_STALL_JUMP    = 1,
  parameter int unsigned NR_STALL_CALL    = 2,
  parameter int unsigned NR_STALL_RETURN  = 2,
  parameter int unsigned SS_DEPTH         = 16,
  parameter bit          OVERFLOW_WRAP    = 1'b0,
  parameter bit          STRICT_UNDERFLOW = 1'b1,
  localparam int unsigned SS_CW           = $clog2(SS_DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  cfi_log_t         log_i,
  input  logic             queue_empty_i,
  output logic             queue_pop_o,
  input  logic             flush_i,
  output exception_t       cfi_fault_o,
  output logic [SS_CW-1:0] ss_count_o
);

  localparam int unsigned MAX_STALL = max4(NR_STALL_BRANCH, NR_STALL_JUMP,
                                           NR_STALL_CALL, NR_STALL_RETURN);
  localparam int unsigned STALL_W   = $clog2(MAX_STALL) + 1;

  typedef logic [STALL_W-1:0] stall_t;

  localparam stall_t STALL_BR  = stall_t'(NR_STALL_BRANCH);
  localparam stall_t STALL_JMP = stall_t'(NR_STALL_JUMP);
  localparam stall_t STALL_CAL = stall_t'(NR_STALL_CALL);
  localparam stall_t STALL_RET = stall_t'(NR_STALL_RETURN);

  cfi_state_e      state_q, state_d;
  stall_t          cnt_q, cnt_d;
  exception_t      fault_q, fault_d;

  logic            pop;
  logic            ss_push, ss_pop, ss_clear, ss_full, ss_empty;
  logic [VLEN-1:0] ss_top, ret_addr;
  logic            take_fault;
  logic [XLEN-1:0] cause_sel;
  stall_t          stall_sel;

  assign ret_addr = log_i.pc + (log_i.is_compressed ? VLEN'(2) : VLEN'(4));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fault_d    = '0;
    pop        = 1'b0;
    ss_push    = 1'b0;
    ss_pop     = 1'b0;
    ss_clear   = 1'b0;
    take_fault = 1'b0;
    cause_sel  = '0;
    stall_sel  = '0;
    // Flush wins over everything, including a pop or fault in the same cycle.
    if (flush_i) begin
      state_d  = CFI_IDLE;
      cnt_d    = '0;
      ss_clear = 1'b1;
    end else begin
      case (state_q)
        CFI_IDLE: begin
          if (!queue_empty_i) begin
            pop = 1'b1;
            case (log_i.flags)
              CFI_FLAG_BRANCH: stall_sel = STALL_BR;
              CFI_FLAG_JUMP:   stall_sel = STALL_JMP;
              CFI_FLAG_CALL: begin
                stall_sel = STALL_CAL;
                if (!ss_full || OVERFLOW_WRAP) begin
                  ss_push = 1'b1;
                end else begin
                  take_fault = 1'b1;
                  cause_sel  = CFI_CAUSE_OVERFLOW;
                end
              end
              CFI_FLAG_RETURN: begin
                stall_sel = STALL_RET;
                if (!ss_empty) begin
                  ss_pop = 1'b1;
                  if (ss_top != log_i.target) begin
                    take_fault = 1'b1;
                    cause_sel  = CFI_CAUSE_MISMATCH;
                  end
                end else if (STRICT_UNDERFLOW) begin
                  take_fault = 1'b1;
                  cause_sel  = CFI_CAUSE_UNDERFLOW;
                end
              end
              default: stall_sel = '0;
            endcase
            cnt_d = stall_sel;
            if (take_fault) begin
              state_d       = CFI_FAULT;
              fault_d.valid = 1'b1;
              fault_d.cause = cause_sel;
              fault_d.tval  = XLEN'(log_i.pc);
            end else if (stall_sel != '0) begin
              state_d = CFI_BUSY;
            end
          end
        end
        CFI_BUSY: begin
          cnt_d = cnt_q - stall_t'(1);
          if (cnt_q == stall_t'(1)) state_d = CFI_IDLE;
        end
        CFI_FAULT: state_d = CFI_FAULT;
        default:   state_d = CFI_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= CFI_IDLE;
      cnt_q   <= '0;
      fault_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  cfi_shadow_stack #(
    .DEPTH (SS_DEPTH),
    .WRAP  (OVERFLOW_WRAP)
  ) u_ss (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (ss_push),
    .pop_i   (ss_pop),
    .clear_i (ss_clear),
    .data_i  (ret_addr),
    .top_o   (ss_top),
    .full_o  (ss_full),
    .empty_o (ss_empty),
    .count_o (ss_count_o)
  );

  assign queue_pop_o = pop;
  assign cfi_fault_o = fault_q;

endmodule

// File: tb/tb_cfi_backend_shadow_stack.sv
// Bench for cfi_backend_shadow_stack: three configurations driven by directed and
// random event streams, checked cycle by cycle against a queue-based model.
module tb_cfi_backend_shadow_stack;
  import cfi_pkg::*;

  logic       clk, rst_n;
  cfi_log_t   log_v    [3];
  logic       qempty_v [3];
  logic       flush_v  [3];
  logic       pop_v    [3];
  exception_t fault_v  [3];
  logic [4:0] cnt0;
  logic [2:0] cnt1, cnt2;

  // Instance 0: default parameters.
  cfi_backend_shadow_stack u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .log_i(log_v[0]), .queue_empty_i(qempty_v[0]),
    .queue_pop_o(pop_v[0]), .flush_i(flush_v[0]), .cfi_fault_o(fault_v[0]), .ss_count_o(cnt0)
  );

  // Instance 1: no stalls, depth 4, faulting overflow, lenient underflow.
  cfi_backend_shadow_stack #(
    .NR_STALL_BRANCH(0), .NR_STALL_JUMP(0), .NR_STALL_CALL(0), .NR_STALL_RETURN(0),
    .SS_DEPTH(4), .OVERFLOW_WRAP(1'b0), .STRICT_UNDERFLOW(1'b0)
  ) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .log_i(log_v[1]), .queue_empty_i(qempty_v[1]),
    .queue_pop_o(pop_v[1]), .flush_i(flush_v[1]), .cfi_fault_o(fault_v[1]), .ss_count_o(cnt1)
  );

  // Instance 2: no stalls, depth 4, wrapping overflow, strict underflow.
  cfi_backend_shadow_stack #(
    .NR_STALL_BRANCH(0), .NR_STALL_JUMP(0), .NR_STALL_CALL(0), .NR_STALL_RETURN(0),
    .SS_DEPTH(4), .OVERFLOW_WRAP(1'b1), .STRICT_UNDERFLOW(1'b1)
  ) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .log_i(log_v[2]), .queue_empty_i(qempty_v[2]),
    .queue_pop_o(pop_v[2]), .flush_i(flush_v[2]), .cfi_fault_o(fault_v[2]), .ss_count_o(cnt2)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  int  cfg_stall  [3][4];
  int  cfg_depth  [3];
  bit  cfg_wrap   [3];
  bit  cfg_strict [3];

  logic [VLEN-1:0] mdl_q [$];
  cfi_log_t        ev_buf [$];
  int              m_busy;
  bit              m_faulted, m_pend;
  logic [XLEN-1:0] m_cause, m_tval;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int get_cnt(input int k);
    case (k)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      default: return int'(cnt2);
    endcase
  endfunction

  function automatic cfi_log_t mk(input logic [3:0] f, input logic [VLEN-1:0] pc,
                                  input logic [VLEN-1:0] tg, input logic c);
    cfi_log_t e;
    e.flags = f; e.pc = pc; e.target = tg; e.is_compressed = c;
    return e;
  endfunction

  function automatic void model_fault(input logic [XLEN-1:0] cause, input logic [VLEN-1:0] pc);
    m_faulted = 1'b1;
    m_pend    = 1'b1;
    m_cause   = cause;
    m_tval    = XLEN'(pc);
  endfunction

  // Spec-level model: a plain queue as the stack, back() is the top.
  function automatic void model_apply(input int k, input cfi_log_t ev);
    logic [VLEN-1:0] ret, top;
    ret    = ev.pc + (ev.is_compressed ? VLEN'(2) : VLEN'(4));
    m_busy = 0;
    case (ev.flags)
      4'b1000: m_busy = cfg_stall[k][0];
      4'b0100: m_busy = cfg_stall[k][1];
      4'b0110: begin
        m_busy = cfg_stall[k][2];
        if (mdl_q.size() < cfg_depth[k]) mdl_q.push_back(ret);
        else if (cfg_wrap[k]) begin
          void'(mdl_q.pop_front());
          mdl_q.push_back(ret);
        end else model_fault(CFI_CAUSE_OVERFLOW, ev.pc);
      end
      4'b0101: begin
        m_busy = cfg_stall[k][3];
        if (mdl_q.size() > 0) begin
          top = mdl_q.pop_back();
          if (top != ev.target) model_fault(CFI_CAUSE_MISMATCH, ev.pc);
        end else if (cfg_strict[k]) model_fault(CFI_CAUSE_UNDERFLOW, ev.pc);
      end
      default: m_busy = 0;
    endcase
  endfunction

  // Feeds ev_buf back to back and checks pop, count and fault every cycle.
  task automatic stream(input int k);
    int idx, post, cyc, n;
    bit exp_pop;
    exception_t e;
    idx = 0; post = 0; cyc = 0; n = ev_buf.size();
    while (cyc < 2000 && post < 3) begin
      @(posedge clk); #1;
      if (idx < n) begin
        log_v[k] = ev_buf[idx];
        qempty_v[k] = 1'b0;
      end else begin
        log_v[k] = mk(4'b0110, VLEN'($urandom()), '0, 1'b0);
        qempty_v[k] = 1'b1;
      end
      @(negedge clk);
      chk($sformatf("count_i%0d_e%0d", k, idx), 160'(get_cnt(k)), 160'(mdl_q.size()));
      e = '0;
      if (m_pend) begin
        e.valid = 1'b1; e.cause = m_cause; e.tval = m_tval;
      end
      chk($sformatf("fault_i%0d_e%0d", k, idx), 160'(fault_v[k]), 160'(e));
      m_pend = 1'b0;
      exp_pop = (idx < n) && !m_faulted && (m_busy == 0);
      chk($sformatf("pop_i%0d_e%0d", k, idx), 160'(pop_v[k]), 160'(exp_pop));
      if (exp_pop) begin
        model_apply(k, ev_buf[idx]);
        idx++;
      end else if (m_busy > 0) begin
        m_busy--;
      end else begin
        post++;
      end
      cyc++;
    end
    chk($sformatf("stream_bound_i%0d", k), 160'(cyc < 2000), 160'(1));
    qempty_v[k] = 1'b1;
  endtask

  task automatic do_flush(input int k);
    @(posedge clk); #1;
    flush_v[k] = 1'b1;
    qempty_v[k] = 1'b0;
    log_v[k] = mk(4'b0110, VLEN'(32'h40), '0, 1'b0);
    @(negedge clk);
    chk($sformatf("flush_pop_i%0d", k), 160'(pop_v[k]), 160'(0));
    @(posedge clk); #1;
    flush_v[k] = 1'b0;
    qempty_v[k] = 1'b1;
    @(negedge clk);
    chk($sformatf("flush_cnt_i%0d", k), 160'(get_cnt(k)), 160'(0));
    chk($sformatf("flush_fault_i%0d", k), 160'(fault_v[k]), 160'(0));
    mdl_q.delete();
    m_faulted = 1'b0; m_pend = 1'b0; m_busy = 0;
  endtask

  task automatic gen_random(input int n);
    logic [VLEN-1:0] g [$];
    cfi_log_t ev;
    int r;
    ev_buf.delete();
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 9);
      ev.pc = VLEN'({$urandom(), $urandom()});
      ev.target = VLEN'({$urandom(), $urandom()});
      ev.is_compressed = 1'($urandom_range(0, 1));
      if (r < 2) ev.flags = 4'b1000;
      else if (r == 2) ev.flags = 4'b0100;
      else if (r < 6) begin
        ev.flags = 4'b0110;
        g.push_back(ev.pc + (ev.is_compressed ? VLEN'(2) : VLEN'(4)));
      end else if (r < 9) begin
        ev.flags = 4'b0101;
        if (g.size() > 0 && $urandom_range(0, 3) != 0) ev.target = g.pop_back();
      end else begin
        case ($urandom_range(0, 3))
          0:       ev.flags = 4'b0000;
          1:       ev.flags = 4'b1111;
          2:       ev.flags = 4'b0011;
          default: ev.flags = 4'b1001;
        endcase
      end
      ev_buf.push_back(ev);
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      cfg_depth[k] = 4;
      for (int j = 0; j < 4; j++) cfg_stall[k][j] = 0;
      qempty_v[k] = 1'b1;
      flush_v[k] = 1'b0;
      log_v[k] = '0;
    end
    cfg_stall[0][0] = 1; cfg_stall[0][1] = 1; cfg_stall[0][2] = 2; cfg_stall[0][3] = 2;
    cfg_depth[0] = 16;
    cfg_wrap[0] = 1'b0; cfg_strict[0] = 1'b1;
    cfg_wrap[1] = 1'b0; cfg_strict[1] = 1'b0;
    cfg_wrap[2] = 1'b1; cfg_strict[2] = 1'b1;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_pop_i%0d", k), 160'(pop_v[k]), 160'(0));
      chk($sformatf("rst_fault_i%0d", k), 160'(fault_v[k]), 160'(0));
      chk($sformatf("rst_cnt_i%0d", k), 160'(get_cnt(k)), 160'(0));
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Back-to-back branches with stall 1: one pop every other cycle.
    do_flush(0);
    ev_buf.delete();
    for (int i = 0; i < 4; i++) ev_buf.push_back(mk(4'b1000, VLEN'(32'h100 + 4 * i), '0, 1'b0));
    stream(0);

    // Matching call/return with zero stalls.
    do_flush(1);
    ev_buf.delete();
    ev_buf.push_back(mk(4'b0110, VLEN'(32'h1000), '0, 1'b0));
    ev_buf.push_back(mk(4'b0101, VLEN'(32'h1800), VLEN'(32'h1004), 1'b0));
    stream(1);

    // Compressed call returns to pc+2, so target pc+4 mismatches; FAULT holds until flush.
    do_flush(0);
    ev_buf.delete();
    ev_buf.push_back(mk(4'b0110, VLEN'(32'h2000), '0, 1'b1));
    ev_buf.push_back(mk(4'b0101, VLEN'(32'h2468), VLEN'(32'h2004), 1'b0));
    ev_buf.push_back(mk(4'b1000, VLEN'(32'h2500), '0, 1'b0));
    stream(0);
    do_flush(0);

    // Five calls into a depth-4 stack: overflow fault.
    do_flush(1);
    ev_buf.delete();
    for (int i = 0; i < 5; i++) ev_buf.push_back(mk(4'b0110, VLEN'(32'h3000 + 16 * i), '0, 1'b0));
    stream(1);

    // Wrapping stack: five calls, four matching returns, fifth return underflows.
    do_flush(2);
    ev_buf.delete();
    for (int i = 0; i < 5; i++) ev_buf.push_back(mk(4'b0110, VLEN'(32'h4000 + 16 * i), '0, 1'b0));
    for (int i = 4; i >= 0; i--)
      ev_buf.push_back(mk(4'b0101, VLEN'(32'h5000 + i), VLEN'(32'h4004 + 16 * i), 1'b0));
    stream(2);

    // Return address wraps modulo 2^VLEN.
    do_flush(2);
    ev_buf.delete();
    ev_buf.push_back(mk(4'b0110, {VLEN{1'b1}} - VLEN'(1), '0, 1'b1));
    ev_buf.push_back(mk(4'b0101, VLEN'(32'h6000), '0, 1'b0));
    ev_buf.push_back(mk(4'b0101, VLEN'(32'h6004), '0, 1'b0));
    stream(2);

    // Lenient underflow and unknown flags: popped, no fault, no stall.
    do_flush(1);
    ev_buf.delete();
    ev_buf.push_back(mk(4'b0101, VLEN'(32'h7000), VLEN'(32'h7777), 1'b0));
    ev_buf.push_back(mk(4'b0000, VLEN'(32'h7010), '0, 1'b0));
    ev_buf.push_back(mk(4'b1000, VLEN'(32'h7020), '0, 1'b0));
    stream(1);

    // Flush in the first BUSY cycle of a call: next cycle is IDLE and pops.
    do_flush(0);
    @(posedge clk); #1;
    log_v[0] = mk(4'b0110, VLEN'(32'h8000), '0, 1'b0);
    qempty_v[0] = 1'b0;
    @(negedge clk);
    chk("busy_call_pop", 160'(pop_v[0]), 160'(1));
    @(posedge clk); #1;
    flush_v[0] = 1'b1;
    log_v[0] = mk(4'b1000, VLEN'(32'h8010), '0, 1'b0);
    @(negedge clk);
    chk("busy_flush_pop", 160'(pop_v[0]), 160'(0));
    @(posedge clk); #1;
    flush_v[0] = 1'b0;
    @(negedge clk);
    chk("busy_flush_idle_pop", 160'(pop_v[0]), 160'(1));
    chk("busy_flush_cnt", 160'(get_cnt(0)), 160'(0));
    @(posedge clk); #1;
    qempty_v[0] = 1'b1;
    repeat (3) @(posedge clk);

    // Random streams on all three configurations.
    for (int r = 0; r < 6; r++) begin
      do_flush(0);
      gen_random(20);
      stream(0);
    end
    for (int r = 0; r < 4; r++) begin
      do_flush(1);
      gen_random(16);
      stream(1);
      do_flush(2);
      gen_random(16);
      stream(2);
    end

    // Asynchronous reset in the middle of BUSY.
    do_flush(0);
    @(posedge clk); #1;
    log_v[0] = mk(4'b0110, VLEN'(32'h9000), '0, 1'b0);
    qempty_v[0] = 1'b0;
    @(negedge clk);
    chk("rstbusy_pop", 160'(pop_v[0]), 160'(1));
    @(posedge clk); #1;
    qempty_v[0] = 1'b1;
    #2;
    chk("rstbusy_cnt_before", 160'(get_cnt(0)), 160'(1));
    rst_n = 1'b0;
    #1;
    chk("rstbusy_cnt", 160'(get_cnt(0)), 160'(0));
    chk("rstbusy_pop_after", 160'(pop_v[0]), 160'(0));
    chk("rstbusy_fault", 160'(fault_v[0]), 160'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstbusy_release_cnt", 160'(get_cnt(0)), 160'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
